text_console_writer: RTL and testbench

//  Write-side companion of the text-mode framebuffer. Accepts an ASCII byte stream over a

---
 rtl/text_mode_pkg.sv | 15 +
 rtl/text_console_writer_if.sv | 12 +
 rtl/text_console_writer.sv | 103 ++++++++++
 tb/tb_text_console_writer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/text_mode_pkg.sv
// text_mode_pkg: shared geometry, control codes and writer states for the text-mode framebuffer.
package text_mode_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int ADDR_W = 12;
  localparam logic [7:0] CLEAR_CHAR = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_e;
  function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
    return ADDR_W'(row) * ADDR_W'(COLS);
  endfunction
endpackage

// File: rtl/text_console_writer_if.sv
// text_console_writer_if: character stream handshake plus text RAM write port.
interface text_console_writer_if;
  import text_mode_pkg::*;
  logic char_valid;
  logic [7:0] char_data;
  logic char_ready;
  logic ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0] ram_wr_data;
  modport master (output char_valid, char_data, input char_ready, ram_wr_en, ram_addr, ram_wr_data);
  modport slave (input char_valid, char_data, output char_ready, ram_wr_en, ram_addr, ram_wr_data);
endinterface

// File: rtl/text_console_writer.sv
// text_console_writer: turns an ASCII stream into text RAM writes at a tracked cursor.
// Clears reuse the registered address/data path, so every RAM write appears one cycle late.
module text_console_writer
  import text_mode_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  text_console_writer_if.slave bus,
  output logic [6:0]           cursor_col,
  output logic [4:0]           cursor_row,
  output logic                 busy
);
  state_e state_q, state_d;
  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic wr_q, wr_d;
  logic [7:0] ch;
  logic acc, prt, col_end, row_end, row_adv, last, bs_ok;
  logic [6:0] bs_col;
  logic [4:0] bs_row;
  assign ch = bus.char_data;
  assign acc = bus.char_valid && state_q == IDLE;
  assign prt = ch >= 8'h20 && ch <= 8'h7E;
  assign col_end = col_q == 7'(COLS - 1);
  assign row_end = row_q == 5'(ROWS - 1);
  assign row_adv = acc && ((prt && col_end) || ch == CH_LF);
  assign last = cnt_q == (state_q == CLEAR_ALL ? ADDR_W'(COLS * ROWS - 1) : ADDR_W'(COLS - 1));
  assign bs_ok = col_q != 7'd0 || row_q != 5'd0;
  assign bs_col = col_q != 7'd0 ? col_q - 7'd1 : 7'(COLS - 1);
  assign bs_row = col_q != 7'd0 ? row_q : row_q - 5'd1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q != IDLE ? (last ? IDLE : state_q) :
              acc && ch == CH_FF ? CLEAR_ALL :
              row_adv && row_end ? CLEAR_ROW : IDLE;
  end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d = cnt_q;
    wr_d = 1'b0;
    if (state_q != IDLE) begin
      wr_d = 1'b1;
      addr_d = (state_q == CLEAR_ROW ? row_base(row_q) : '0) + cnt_q;
      data_d = CLEAR_CHAR;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end else if (acc) begin
      if (prt) begin
        wr_d = 1'b1;
        addr_d = row_base(row_q) + ADDR_W'(col_q);
        data_d = ch;
        col_d = col_end ? 7'd0 : col_q + 7'd1;
      end else if (ch == CH_CR || ch == CH_LF) begin
        col_d = 7'd0;
      end else if (ch == CH_BS && bs_ok) begin
        wr_d = 1'b1;
        col_d = bs_col;
        row_d = bs_row;
        addr_d = row_base(bs_row) + ADDR_W'(bs_col);
        data_d = CLEAR_CHAR;
      end else if (ch == CH_FF) begin
        col_d = 7'd0;
        row_d = 5'd0;
      end
      if (row_adv) row_d = row_end ? 5'd0 : row_q + 5'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      wr_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
    end
  end
  always_comb begin
    bus.char_ready = state_q == IDLE;
    busy = state_q != IDLE;
    bus.ram_wr_en = wr_q;
    bus.ram_addr = addr_q;
    bus.ram_wr_data = data_q;
    cursor_col = col_q;
    cursor_row = row_q;
  end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed scenario checks of the text console writer.
module tb_text_console_writer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic busy;
  int checks = 0;
  int errors = 0;
  text_console_writer_if bus();
  text_console_writer #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] c);
    int t = 0;
    while (!bus.char_ready && t < 5000) begin @(negedge clk); t++; end
    checks++;
    if (bus.char_ready !== 1'b1) begin errors++; $display("FAIL send_ready: char_ready=%b, want 1 within budget", bus.char_ready); end
    bus.char_valid = 1'b1;
    bus.char_data = c;
    @(posedge clk);
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic collect_clear(input int base, input int n, input string name);
    int bad = 0;
    int first = -1;
    checks++;
    if (bus.char_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s_entry: ready=%b busy=%b, want ready=0 busy=1", name, bus.char_ready, busy); end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 12'(base + k - 1) || bus.ram_wr_data !== 8'h20 || bus.char_ready !== (k == n)) begin
        bad++;
        if (first < 0) first = k - 1;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_seq: %0d bad cycles from index %0d, want %0d writes of 0x20 ascending from %0d", name, bad, first, n, base); end
  endtask

  task automatic check_idle(input string name, input logic [6:0] col, input logic [4:0] row);
    @(negedge clk);
    checks++;
    if (bus.ram_wr_en !== 1'b0 || bus.char_ready !== 1'b1 || cursor_col !== col || cursor_row !== row) begin
      errors++;
      $display("FAIL %s_idle: wr=%b ready=%b cursor=(%0d,%0d), want wr=0 ready=1 cursor=(%0d,%0d)", name, bus.ram_wr_en, bus.char_ready, cursor_col, cursor_row, col, row);
    end
  endtask

  task automatic test_reset();
    bus.char_valid = 1'b0;
    bus.char_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ram_wr_en !== 1'b0 || bus.ram_addr !== 12'd0 || bus.ram_wr_data !== 8'h00) begin errors++; $display("FAIL reset_ram: wr=%b addr=%0d data=%h, want 0/0/00", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data); end
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || bus.char_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reset_state: cursor=(%0d,%0d) ready=%b busy=%b, want (0,0) 0 1", cursor_col, cursor_row, bus.char_ready, busy); end
    reset_n = 1'b1;
    collect_clear(0, 2400, "reset_clear");
    check_idle("reset_clear", 7'd0, 5'd0);
  endtask

  task automatic test_print();
    send(8'h41);
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 12'd0 || bus.ram_wr_data !== 8'h41 || cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL print_A: wr=%b addr=%0d data=%h cursor=(%0d,%0d), want 1 0 41 (1,0)", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, cursor_col, cursor_row);
    end
    foreach (ignored[i]) begin
      send(ignored[i]);
      checks++;
      if (bus.ram_wr_en !== 1'b0 || cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
        errors++; $display("FAIL ignore_%h: wr=%b cursor=(%0d,%0d), want 0 (1,0)", ignored[i], bus.ram_wr_en, cursor_col, cursor_row);
      end
    end
  endtask
  logic [7:0] ignored [3] = '{8'h07, 8'h7F, 8'h80};

  task automatic test_row_wrap();
    int bad = 0;
    send(8'h0D);
    for (int i = 0; i < 80; i++) begin
      send(8'h42);
      if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 12'(i) || bus.ram_wr_data !== 8'h42) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL row0_fill: %0d bad writes, want 80 writes of 42 at 0..79", bad); end
    checks++;
    if (bus.ram_addr !== 12'd79 || cursor_col !== 7'd0 || cursor_row !== 5'd1) begin errors++; $display("FAIL row0_end: addr=%0d cursor=(%0d,%0d), want 79 (0,1)", bus.ram_addr, cursor_col, cursor_row); end
    repeat (28) send(8'h0A);
    repeat (5) send(8'h43);
    checks++;
    if (bus.ram_addr !== 12'd2324 || cursor_col !== 7'd5 || cursor_row !== 5'd29) begin errors++; $display("FAIL row29_pos: addr=%0d cursor=(%0d,%0d), want 2324 (5,29)", bus.ram_addr, cursor_col, cursor_row); end
    send(8'h0A);
    checks++;
    if (bus.ram_wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin errors++; $display("FAIL lf_wrap: wr=%b cursor=(%0d,%0d), want 0 (0,0)", bus.ram_wr_en, cursor_col, cursor_row); end
    collect_clear(0, 80, "lf_row_clear");
    check_idle("lf_row_clear", 7'd0, 5'd0);
  endtask

  task automatic test_last_cell();
    repeat (29) send(8'h0A);
    repeat (79) send(8'h44);
    send(8'h45);
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 12'd2399 || bus.ram_wr_data !== 8'h45 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL last_cell: wr=%b addr=%0d data=%h cursor=(%0d,%0d), want 1 2399 45 (0,0)", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, cursor_col, cursor_row);
    end
    collect_clear(0, 80, "last_cell_clear");
    check_idle("last_cell_clear", 7'd0, 5'd0);
  endtask

  task automatic test_bs_cr();
    send(8'h0A);
    send(8'h08);
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 12'd79 || bus.ram_wr_data !== 8'h20 || cursor_col !== 7'd79 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL bs_rowup: wr=%b addr=%0d data=%h cursor=(%0d,%0d), want 1 79 20 (79,0)", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, cursor_col, cursor_row);
    end
    send(8'h0D);
    send(8'h08);
    checks++;
    if (bus.ram_wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin errors++; $display("FAIL bs_origin: wr=%b cursor=(%0d,%0d), want 0 (0,0)", bus.ram_wr_en, cursor_col, cursor_row); end
    repeat (3) send(8'h0A);
    repeat (12) send(8'h46);
    send(8'h0D);
    checks++;
    if (bus.ram_wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd3) begin errors++; $display("FAIL cr: wr=%b cursor=(%0d,%0d), want 0 (0,3)", bus.ram_wr_en, cursor_col, cursor_row); end
    send(8'h47);
    send(8'h08);
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 12'd240 || bus.ram_wr_data !== 8'h20 || cursor_col !== 7'd0 || cursor_row !== 5'd3) begin
      errors++; $display("FAIL bs_col: wr=%b addr=%0d data=%h cursor=(%0d,%0d), want 1 240 20 (0,3)", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, cursor_col, cursor_row);
    end
  endtask

  task automatic test_ff();
    repeat (7) send(8'h0A);
    repeat (40) send(8'h48);
    checks++;
    if (cursor_col !== 7'd40 || cursor_row !== 5'd10) begin errors++; $display("FAIL ff_setup: cursor=(%0d,%0d), want (40,10)", cursor_col, cursor_row); end
    bus.char_valid = 1'b1;
    bus.char_data = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    bus.char_data = 8'h4A;
    checks++;
    if (bus.ram_wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin errors++; $display("FAIL ff_home: wr=%b cursor=(%0d,%0d), want 0 (0,0)", bus.ram_wr_en, cursor_col, cursor_row); end
    collect_clear(0, 2400, "ff_clear");
    @(negedge clk);
    bus.char_valid = 1'b0;
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 12'd0 || bus.ram_wr_data !== 8'h4A || cursor_col !== 7'd1) begin
      errors++; $display("FAIL ff_held: wr=%b addr=%0d data=%h col=%0d, want 1 0 4a 1", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, cursor_col);
    end
    check_idle("ff_once", 7'd1, 5'd0);
  endtask

  task automatic test_reset_mid();
    send(8'h0C);
    repeat (1000) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_wr_en !== 1'b0 || bus.ram_addr !== 12'd0 || bus.ram_wr_data !== 8'h00 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL reset_mid: wr=%b addr=%0d data=%h cursor=(%0d,%0d), want 0 0 00 (0,0)", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, cursor_col, cursor_row);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    collect_clear(0, 2400, "restart_clear");
    check_idle("restart_clear", 7'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_print();
    test_row_wrap();
    test_last_cell();
    test_bs_cr();
    test_ff();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
